// File: rtl/dtc_cmd_router.sv
// dtc_cmd_router: routes dtc_rx commands to one of NUM_TGT targets (or all, for broadcast writes), gathers acks under a timeout and posts one reply to dtc_tx.
// Latency: tgt_exec one cycle after the cmd_exec rise, reply one cycle after the completing ack; reply held until frame_st, commands arriving while busy are dropped and counted.
module dtc_cmd_router #(
  parameter int NUM_TGT = 4,
  parameter int SEL_W   = 2,
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 20,
  parameter int TIMEOUT = 1023
) (
  input  logic                      rdoclk,
  input  logic                      reset,
  input  logic                      cmd_exec,
  input  logic                      cmd_rnw,
  input  logic                      cmd_bcast,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [DATA_W-1:0]         cmd_data,
  output logic                      cmd_ack,
  output logic [NUM_TGT-1:0]        tgt_exec,
  output logic                      tgt_rnw,
  output logic [ADDR_W-1:0]         tgt_addr,
  output logic [DATA_W-1:0]         tgt_wdata,
  input  logic [NUM_TGT*DATA_W-1:0] tgt_rdata,
  input  logic [NUM_TGT-1:0]        tgt_ack,
  output logic                      reply_rdy,
  output logic [31:0]               reply_addr,
  output logic [31:0]               reply_data,
  input  logic                      frame_st,
  output logic [7:0]                drop_cnt,
  input  logic                      CntRst
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ACK = 2'd1;
  localparam logic [1:0] REPLY    = 2'd2;

  localparam logic [NUM_TGT-1:0] TGT_ALL  = {NUM_TGT{1'b1}};
  localparam logic [NUM_TGT-1:0] TGT_ONE0 = NUM_TGT'(1);

  typedef struct packed {
    logic        timeout;
    logic        bcast;
    logic        badtgt;
    logic [28:0] rdata;
  } reply_dat_t;

  typedef struct packed {
    logic        rnw;
    logic [30:0] addr;
  } reply_adr_t;

  logic [1:0]         state;
  logic               exec_q;
  logic               bcast_q;
  logic               timeout_q;
  logic               badtgt_q;
  logic [SEL_W-1:0]   sel_q;
  logic [NUM_TGT-1:0] ack_mask;
  logic [TMR_W-1:0]   timer;
  logic [DATA_W-1:0]  rdata_q;

  logic               start;
  logic [SEL_W-1:0]   sel_in;
  logic               bad_req;
  logic [NUM_TGT-1:0] ack_vld;
  logic [NUM_TGT-1:0] mask_nxt;
  logic               done;
  logic               tmo;
  logic [DATA_W-1:0]  sel_rdata;
  reply_dat_t         rep_dat;
  reply_adr_t         rep_adr;

  assign start   = cmd_exec & ~exec_q;
  assign sel_in  = cmd_addr[ADDR_W-1 -: SEL_W];
  assign bad_req = (int'(sel_in) >= NUM_TGT) || (cmd_bcast && cmd_rnw);

  // Acks on targets we are not currently driving are ignored.
  assign ack_vld  = tgt_ack & tgt_exec;
  assign mask_nxt = ack_mask | ack_vld;
  assign done     = bcast_q ? (mask_nxt == TGT_ALL) : (|ack_vld);
  assign tmo      = (timer == TMR_W'(TIMEOUT));

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (sel_q == SEL_W'(i)) sel_rdata = tgt_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge rdoclk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      exec_q    <= 1'b0;
      bcast_q   <= 1'b0;
      timeout_q <= 1'b0;
      badtgt_q  <= 1'b0;
      sel_q     <= '0;
      ack_mask  <= '0;
      timer     <= '0;
      rdata_q   <= '0;
      cmd_ack   <= 1'b0;
      tgt_exec  <= '0;
      tgt_rnw   <= 1'b0;
      tgt_addr  <= '0;
      tgt_wdata <= '0;
      reply_rdy <= 1'b0;
    end else begin
      exec_q  <= cmd_exec;
      cmd_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tgt_rnw   <= cmd_rnw;
            tgt_addr  <= cmd_addr;
            tgt_wdata <= cmd_data;
            bcast_q   <= cmd_bcast;
            sel_q     <= sel_in;
            timeout_q <= 1'b0;
            rdata_q   <= '0;
            ack_mask  <= '0;
            timer     <= '0;
            badtgt_q  <= bad_req;
            if (bad_req) begin
              state     <= REPLY;
              reply_rdy <= 1'b1;
              cmd_ack   <= 1'b1;
            end else begin
              state    <= WAIT_ACK;
              tgt_exec <= cmd_bcast ? TGT_ALL : (TGT_ONE0 << sel_in);
            end
          end
        end
        WAIT_ACK: begin
          timer    <= timer + TMR_W'(1);
          ack_mask <= mask_nxt;
          tgt_exec <= tgt_exec & ~tgt_ack;
          // A completing ack on the timeout edge wins over the timeout.
          if (done) begin
            if (!bcast_q && tgt_rnw) rdata_q <= sel_rdata;
            tgt_exec  <= '0;
            state     <= REPLY;
            reply_rdy <= 1'b1;
            cmd_ack   <= 1'b1;
          end else if (tmo) begin
            timeout_q <= 1'b1;
            tgt_exec  <= '0;
            state     <= REPLY;
            reply_rdy <= 1'b1;
            cmd_ack   <= 1'b1;
          end
        end
        REPLY: begin
          if (frame_st) begin
            reply_rdy <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge rdoclk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= 8'd0;
    end else if (CntRst) begin
      drop_cnt <= 8'd0;
    end else if (start && (state != IDLE) && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Reply fields only change on command capture or completion, so they are stable for the whole REPLY phase.
  always_comb begin
    rep_adr.rnw     = tgt_rnw;
    rep_adr.addr    = 31'(tgt_addr);
    rep_dat.timeout = timeout_q;
    rep_dat.bcast   = bcast_q;
    rep_dat.badtgt  = badtgt_q;
    rep_dat.rdata   = 29'(rdata_q);
  end

  assign reply_addr = rep_adr;
  assign reply_data = rep_dat;

endmodule
